control_fsm: RTL and testbench
==============================

CONTROL_FSM -- requirements
Module: control_fsm

Interface
REQ-001 SHALL have port clk  input  1  single system clock, all state updates on its rising edge.
REQ-002 SHALL have port reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-003 SHALL have port opcode  input  6  instruction bits [31:26] from instruction register, stable from DECODE onward.
REQ-004 SHALL have port funct  input  6  instruction bits [5:0], used only for opcode 0x00.
REQ-005 SHALL have port overflow  input  1  ALU signed-overflow flag for current ALU operation.
REQ-006 SHALL have port pc_write  output  1  unconditional PC write enable, feeds branch-condition combiner.
REQ-007 SHALL have ports isBEQ, isBNE, isBGT, isBLE  output  1 each  branch-type qualifiers for branch-condition combiner.
REQ-008 SHALL have port pc_source  output  2  PC mux: 00 ALU result, 01 ALUOut, 10 jump target, 11 exception vector.
REQ-009 SHALL have ports ir_wr, mem_wr, reg_wr, epc_wr  output  1 each  write enables: IR, data memory, register file, EPC.
REQ-010 SHALL have port wb_sel  output  2  write-back: 00 ALUOut to rd, 01 ALUOut to rt, 10 MDR to rt.
REQ-011 SHALL have ports alu_src_a (1), alu_src_b (2), alu_op (3)  output  ALU controls; A: 0 PC, 1 regA; B: 00 regB, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2; op: 000 add, 001 sub, 010 and.
REQ-012 SHALL have port state  output  4  current state encoding, for debug.

Function
REQ-013 SHALL be a Moore FSM; every output a pure function of state, except isB* and alu_op, which also depend on opcode/funct.
REQ-014 State encodings SHALL be: FETCH 0, FETCH_W 1, DECODE 2, EXEC_R 3, EXEC_I 4, WB_R 5, WB_I 6, MEM_ADDR 7, MEM_RD 8, MEM_RD_W 9, WB_LW 10, MEM_WR 11, BRANCH 12, JUMP 13, EXC 14.
REQ-015 Outputs not listed for a state SHALL be 0.
REQ-016 FETCH: alu_src_a=0, alu_src_b=01, alu_op=000; next FETCH_W (one memory wait cycle).
REQ-017 FETCH_W: ir_wr=1, pc_write=1, pc_source=00, same ALU controls as FETCH; next DECODE.
REQ-018 DECODE: alu_src_a=0, alu_src_b=11, alu_op=000 (branch target into ALUOut); next state selected by opcode.
REQ-019 Opcode decode SHALL be: 0x00 -> EXEC_R; 0x08 addi -> EXEC_I; 0x23 lw and 0x2B sw -> MEM_ADDR; 0x04/0x05/0x06/0x07 -> BRANCH; 0x02 -> JUMP; any other opcode -> FETCH (treated as NOP).
REQ-020 EXEC_R: alu_src_a=1, alu_src_b=00, alu_op from funct: 0x20 -> 000, 0x22 -> 001, 0x24 -> 010, other -> 000; next WB_R.
REQ-021 EXEC_I: alu_src_a=1, alu_src_b=10, alu_op=000; next WB_I.
REQ-022 WB_R: reg_wr=1, wb_sel=00. WB_I: reg_wr=1, wb_sel=01. WB_LW: reg_wr=1, wb_sel=10. Next state of all three SHALL be FETCH.
REQ-023 MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=000; next MEM_RD for 0x23, MEM_WR for 0x2B.
REQ-024 MEM_RD -> MEM_RD_W -> WB_LW, with no enables asserted in MEM_RD or MEM_RD_W; MEM_WR: mem_wr=1 for exactly one cycle, next FETCH.
REQ-025 BRANCH: alu_src_a=1, alu_src_b=00, alu_op=001, pc_source=01, pc_write=0; exactly one isB* SHALL be 1 (0x04 isBEQ, 0x05 isBNE, 0x06 isBLE, 0x07 isBGT); next FETCH.
REQ-026 JUMP: pc_write=1, pc_source=10; next FETCH.
REQ-027 Latency SHALL be: R-type/addi 5 cycles, lw 7, sw 5, branch 4, jump 4, undefined opcode 3 (FETCH through return to FETCH).
REQ-028 At most one isB* SHALL be high in any cycle, and never while pc_write=1.

Reset
REQ-029 reset=1 at a rising edge SHALL force state FETCH in any state, including mid-instruction; all write enables are therefore 0 in the following cycle.
REQ-030 Reset SHALL take priority over every transition, including EXC.

Configuration
REQ-031 With OVERFLOW_EXC_EN defined: in EXEC_R (funct 0x20/0x22) or EXEC_I with overflow=1, the next state SHALL be EXC, not WB_*; EXC asserts epc_wr=1, pc_write=1, pc_source=11 for one cycle, then goes to FETCH, with no register write-back.
REQ-032 Without OVERFLOW_EXC_EN: overflow SHALL be ignored, state 14 SHALL be unreachable, and epc_wr SHALL be tied to 0.

Verification
REQ-033 reset held 2 cycles, then released -> state=0, then 1; ir_wr=1 and pc_write=1 only in state 1.
REQ-034 opcode=0x00, funct=0x22 -> states 0,1,2,3,5,0; alu_op=001 in state 3; reg_wr=1 and wb_sel=00 in state 5 only.
REQ-035 opcode=0x23 -> states 0,1,2,7,8,9,10,0; wb_sel=10 and reg_wr=1 in state 10. opcode=0x2B -> mem_wr=1 in state 11 only.
REQ-036 opcode=0x06 -> state 12 with isBLE=1, other isB*=0, pc_write=0, pc_source=01, alu_op=001; opcode=0x3F -> states 0,1,2,0.
REQ-037 With OVERFLOW_EXC_EN: opcode=0x08, overflow=1 in state 4 -> state 14 (epc_wr=1, pc_source=11), no reg_wr; without the macro -> state 6 with reg_wr=1.
REQ-038 reset asserted during state 9 -> state 0 next cycle, with no reg_wr pulse.

Source files
------------

// File: rtl/control_fsm.sv
// ============================================================================
// Module      : control_fsm
// Description : Multi-cycle processor control FSM (Moore, registered outputs).
//               Optional overflow exception path enabled by OVERFLOW_EXC_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module control_fsm (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       overflow,
    output logic       pc_write,
    output logic       isBEQ,
    output logic       isBNE,
    output logic       isBGT,
    output logic       isBLE,
    output logic [1:0] pc_source,
    output logic       ir_wr,
    output logic       mem_wr,
    output logic       reg_wr,
    output logic       epc_wr,
    output logic [1:0] wb_sel,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_op,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_FETCH_W  = 4'd1,
        S_DECODE   = 4'd2,
        S_EXEC_R   = 4'd3,
        S_EXEC_I   = 4'd4,
        S_WB_R     = 4'd5,
        S_WB_I     = 4'd6,
        S_MEM_ADDR = 4'd7,
        S_MEM_RD   = 4'd8,
        S_MEM_RD_W = 4'd9,
        S_WB_LW    = 4'd10,
        S_MEM_WR   = 4'd11,
        S_BRANCH   = 4'd12,
        S_JUMP     = 4'd13,
        S_EXC      = 4'd14
    } state_t;

    typedef struct packed {
        logic       pc_write;
        logic       is_beq;
        logic       is_bne;
        logic       is_bgt;
        logic       is_ble;
        logic [1:0] pc_source;
        logic       ir_wr;
        logic       mem_wr;
        logic       reg_wr;
        logic       epc_wr;
        logic [1:0] wb_sel;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
    } ctl_t;

    localparam logic [5:0] c_OP_RTYPE = 6'h00;
    localparam logic [5:0] c_OP_J     = 6'h02;
    localparam logic [5:0] c_OP_BEQ   = 6'h04;
    localparam logic [5:0] c_OP_BNE   = 6'h05;
    localparam logic [5:0] c_OP_BLE   = 6'h06;
    localparam logic [5:0] c_OP_BGT   = 6'h07;
    localparam logic [5:0] c_OP_ADDI  = 6'h08;
    localparam logic [5:0] c_OP_LW    = 6'h23;
    localparam logic [5:0] c_OP_SW    = 6'h2B;
    localparam logic [5:0] c_FN_ADD   = 6'h20;
    localparam logic [5:0] c_FN_SUB   = 6'h22;
    localparam logic [5:0] c_FN_AND   = 6'h24;

    state_t state_q;
    state_t state_d;
    ctl_t   ctl_q;
    ctl_t   ctl_d;

    // Output decode of a given state; used on the next state so outputs are
    // registered yet still line up with the state they belong to.
    function automatic ctl_t decode_ctl(input state_t s, input logic [5:0] op,
                                        input logic [5:0] fn);
        ctl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.alu_src_b = 2'b01;
            end
            S_FETCH_W: begin
                c.ir_wr     = 1'b1;
                c.pc_write  = 1'b1;
                c.alu_src_b = 2'b01;
            end
            S_DECODE: begin
                c.alu_src_b = 2'b11;
            end
            S_EXEC_R: begin
                c.alu_src_a = 1'b1;
                case (fn)
                    c_FN_SUB: c.alu_op = 3'b001;
                    c_FN_AND: c.alu_op = 3'b010;
                    default:  c.alu_op = 3'b000;
                endcase
            end
            S_EXEC_I, S_MEM_ADDR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
            end
            S_WB_R: begin
                c.reg_wr = 1'b1;
            end
            S_WB_I: begin
                c.reg_wr = 1'b1;
                c.wb_sel = 2'b01;
            end
            S_WB_LW: begin
                c.reg_wr = 1'b1;
                c.wb_sel = 2'b10;
            end
            S_MEM_WR: begin
                c.mem_wr = 1'b1;
            end
            S_BRANCH: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = 3'b001;
                c.pc_source = 2'b01;
                c.is_beq    = (op == c_OP_BEQ);
                c.is_bne    = (op == c_OP_BNE);
                c.is_ble    = (op == c_OP_BLE);
                c.is_bgt    = (op == c_OP_BGT);
            end
            S_JUMP: begin
                c.pc_write  = 1'b1;
                c.pc_source = 2'b10;
            end
`ifdef OVERFLOW_EXC_EN
            S_EXC: begin
                c.epc_wr    = 1'b1;
                c.pc_write  = 1'b1;
                c.pc_source = 2'b11;
            end
`endif
            default: c = '0;
        endcase
        return c;
    endfunction

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:   state_d = S_FETCH_W;
            S_FETCH_W: state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    c_OP_RTYPE:                           state_d = S_EXEC_R;
                    c_OP_ADDI:                            state_d = S_EXEC_I;
                    c_OP_LW, c_OP_SW:                     state_d = S_MEM_ADDR;
                    c_OP_BEQ, c_OP_BNE, c_OP_BLE, c_OP_BGT: state_d = S_BRANCH;
                    c_OP_J:                               state_d = S_JUMP;
                    default:                              state_d = S_FETCH;
                endcase
            end
            S_EXEC_R: begin
                state_d = S_WB_R;
`ifdef OVERFLOW_EXC_EN
                if (overflow && ((funct == c_FN_ADD) || (funct == c_FN_SUB)))
                    state_d = S_EXC;
`endif
            end
            S_EXEC_I: begin
                state_d = S_WB_I;
`ifdef OVERFLOW_EXC_EN
                if (overflow)
                    state_d = S_EXC;
`endif
            end
            S_MEM_ADDR: state_d = (opcode == c_OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:   state_d = S_MEM_RD_W;
            S_MEM_RD_W: state_d = S_WB_LW;
            S_WB_R, S_WB_I, S_WB_LW, S_MEM_WR,
            S_BRANCH, S_JUMP, S_EXC: state_d = S_FETCH;
            default:    state_d = S_FETCH;
        endcase
    end

    always_comb begin
        ctl_d = decode_ctl(state_d, opcode, funct);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            ctl_q   <= decode_ctl(S_FETCH, opcode, funct);
        end else begin
            state_q <= state_d;
            ctl_q   <= ctl_d;
        end
    end

    assign state     = state_q;
    assign pc_write  = ctl_q.pc_write;
    assign isBEQ     = ctl_q.is_beq;
    assign isBNE     = ctl_q.is_bne;
    assign isBGT     = ctl_q.is_bgt;
    assign isBLE     = ctl_q.is_ble;
    assign pc_source = ctl_q.pc_source;
    assign ir_wr     = ctl_q.ir_wr;
    assign mem_wr    = ctl_q.mem_wr;
    assign reg_wr    = ctl_q.reg_wr;
    assign wb_sel    = ctl_q.wb_sel;
    assign alu_src_a = ctl_q.alu_src_a;
    assign alu_src_b = ctl_q.alu_src_b;
    assign alu_op    = ctl_q.alu_op;

`ifdef OVERFLOW_EXC_EN
    assign epc_wr = ctl_q.epc_wr;
`else
    // No exception path: overflow is ignored and EPC is never written.
    logic unused_ok;
    assign unused_ok = overflow ^ ctl_q.epc_wr;
    assign epc_wr    = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_control_fsm.sv
// ============================================================================
// Module      : tb_control_fsm
// Description : Table-driven self-checking bench for control_fsm.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_control_fsm;

    logic       clk;
    logic       reset;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       overflow;
    logic       pc_write, isBEQ, isBNE, isBGT, isBLE;
    logic [1:0] pc_source;
    logic       ir_wr, mem_wr, reg_wr, epc_wr;
    logic [1:0] wb_sel;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [3:0] state;

    control_fsm dut (
        .clk       (clk),
        .reset     (reset),
        .opcode    (opcode),
        .funct     (funct),
        .overflow  (overflow),
        .pc_write  (pc_write),
        .isBEQ     (isBEQ),
        .isBNE     (isBNE),
        .isBGT     (isBGT),
        .isBLE     (isBLE),
        .pc_source (pc_source),
        .ir_wr     (ir_wr),
        .mem_wr    (mem_wr),
        .reg_wr    (reg_wr),
        .epc_wr    (epc_wr),
        .wb_sel    (wb_sel),
        .alu_src_a (alu_src_a),
        .alu_src_b (alu_src_b),
        .alu_op    (alu_op),
        .state     (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {pc_write, isBEQ,isBNE,isBGT,isBLE, pc_source, ir_wr,mem_wr,reg_wr,epc_wr,
    //  wb_sel, alu_src_a, alu_src_b, alu_op}
    localparam logic [18:0] E_FETCH   = 19'b0_0000_00_0000_00_0_01_000;
    localparam logic [18:0] E_FW      = 19'b1_0000_00_1000_00_0_01_000;
    localparam logic [18:0] E_DEC     = 19'b0_0000_00_0000_00_0_11_000;
    localparam logic [18:0] E_XR_ADD  = 19'b0_0000_00_0000_00_1_00_000;
    localparam logic [18:0] E_XR_SUB  = 19'b0_0000_00_0000_00_1_00_001;
    localparam logic [18:0] E_XR_AND  = 19'b0_0000_00_0000_00_1_00_010;
    localparam logic [18:0] E_XI      = 19'b0_0000_00_0000_00_1_10_000;
    localparam logic [18:0] E_WBR     = 19'b0_0000_00_0010_00_0_00_000;
    localparam logic [18:0] E_WBI     = 19'b0_0000_00_0010_01_0_00_000;
    localparam logic [18:0] E_WBLW    = 19'b0_0000_00_0010_10_0_00_000;
    localparam logic [18:0] E_ZERO    = 19'b0_0000_00_0000_00_0_00_000;
    localparam logic [18:0] E_MEMWR   = 19'b0_0000_00_0100_00_0_00_000;
    localparam logic [18:0] E_BEQ     = 19'b0_1000_01_0000_00_1_00_001;
    localparam logic [18:0] E_BNE     = 19'b0_0100_01_0000_00_1_00_001;
    localparam logic [18:0] E_BGT     = 19'b0_0010_01_0000_00_1_00_001;
    localparam logic [18:0] E_BLE     = 19'b0_0001_01_0000_00_1_00_001;
    localparam logic [18:0] E_JUMP    = 19'b1_0000_10_0000_00_0_00_000;
    localparam logic [18:0] E_EXC     = 19'b1_0000_11_0001_00_0_00_000;

    typedef struct {
        logic        rst;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic        ovf;
        logic [3:0]  st;
        logic [18:0] ex;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_errors = 0;

    function automatic logic [18:0] actual_ctl();
        return {pc_write, isBEQ, isBNE, isBGT, isBLE, pc_source, ir_wr, mem_wr,
                reg_wr, epc_wr, wb_sel, alu_src_a, alu_src_b, alu_op};
    endfunction

    task automatic add(input logic r, input logic [5:0] op, input logic [5:0] fn,
                       input logic ovf, input logic [3:0] st, input logic [18:0] ex);
        vec_t v;
        v.rst = r; v.op = op; v.fn = fn; v.ovf = ovf; v.st = st; v.ex = ex;
        vecs.push_back(v);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_val(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    int lat_ops[7] = '{6'h00, 6'h08, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h3F};
    int lat_exp[7] = '{5, 5, 7, 5, 4, 4, 3};

    initial begin
        reset = 1'b1; opcode = 6'h00; funct = 6'h22; overflow = 1'b0;

        // reset held two cycles, then sub R-type
        add(1, 6'h00, 6'h22, 0, 0, E_FETCH);
        add(1, 6'h00, 6'h22, 0, 0, E_FETCH);
        add(0, 6'h00, 6'h22, 0, 1, E_FW);
        add(0, 6'h00, 6'h22, 0, 2, E_DEC);
        add(0, 6'h00, 6'h22, 0, 3, E_XR_SUB);
        add(0, 6'h00, 6'h22, 0, 5, E_WBR);
        add(0, 6'h00, 6'h22, 0, 0, E_FETCH);
        // add R-type
        add(0, 6'h00, 6'h20, 0, 1, E_FW);
        add(0, 6'h00, 6'h20, 0, 2, E_DEC);
        add(0, 6'h00, 6'h20, 0, 3, E_XR_ADD);
        add(0, 6'h00, 6'h20, 0, 5, E_WBR);
        add(0, 6'h00, 6'h20, 0, 0, E_FETCH);
        // and R-type: overflow never raises an exception here
        add(0, 6'h00, 6'h24, 1, 1, E_FW);
        add(0, 6'h00, 6'h24, 1, 2, E_DEC);
        add(0, 6'h00, 6'h24, 1, 3, E_XR_AND);
        add(0, 6'h00, 6'h24, 1, 5, E_WBR);
        add(0, 6'h00, 6'h24, 1, 0, E_FETCH);
        // unknown funct defaults to add
        add(0, 6'h00, 6'h27, 0, 1, E_FW);
        add(0, 6'h00, 6'h27, 0, 2, E_DEC);
        add(0, 6'h00, 6'h27, 0, 3, E_XR_ADD);
        add(0, 6'h00, 6'h27, 0, 5, E_WBR);
        add(0, 6'h00, 6'h27, 0, 0, E_FETCH);
        // lw
        add(0, 6'h23, 6'h00, 0, 1, E_FW);
        add(0, 6'h23, 6'h00, 0, 2, E_DEC);
        add(0, 6'h23, 6'h00, 0, 7, E_XI);
        add(0, 6'h23, 6'h00, 0, 8, E_ZERO);
        add(0, 6'h23, 6'h00, 0, 9, E_ZERO);
        add(0, 6'h23, 6'h00, 0, 10, E_WBLW);
        add(0, 6'h23, 6'h00, 0, 0, E_FETCH);
        // sw
        add(0, 6'h2B, 6'h00, 0, 1, E_FW);
        add(0, 6'h2B, 6'h00, 0, 2, E_DEC);
        add(0, 6'h2B, 6'h00, 0, 7, E_XI);
        add(0, 6'h2B, 6'h00, 0, 11, E_MEMWR);
        add(0, 6'h2B, 6'h00, 0, 0, E_FETCH);
        // branches
        add(0, 6'h04, 6'h00, 0, 1, E_FW);
        add(0, 6'h04, 6'h00, 0, 2, E_DEC);
        add(0, 6'h04, 6'h00, 0, 12, E_BEQ);
        add(0, 6'h04, 6'h00, 0, 0, E_FETCH);
        add(0, 6'h05, 6'h00, 0, 1, E_FW);
        add(0, 6'h05, 6'h00, 0, 2, E_DEC);
        add(0, 6'h05, 6'h00, 0, 12, E_BNE);
        add(0, 6'h05, 6'h00, 0, 0, E_FETCH);
        add(0, 6'h06, 6'h00, 0, 1, E_FW);
        add(0, 6'h06, 6'h00, 0, 2, E_DEC);
        add(0, 6'h06, 6'h00, 0, 12, E_BLE);
        add(0, 6'h06, 6'h00, 0, 0, E_FETCH);
        add(0, 6'h07, 6'h00, 0, 1, E_FW);
        add(0, 6'h07, 6'h00, 0, 2, E_DEC);
        add(0, 6'h07, 6'h00, 0, 12, E_BGT);
        add(0, 6'h07, 6'h00, 0, 0, E_FETCH);
        // jump
        add(0, 6'h02, 6'h00, 0, 1, E_FW);
        add(0, 6'h02, 6'h00, 0, 2, E_DEC);
        add(0, 6'h02, 6'h00, 0, 13, E_JUMP);
        add(0, 6'h02, 6'h00, 0, 0, E_FETCH);
        // undefined opcode
        add(0, 6'h3F, 6'h00, 0, 1, E_FW);
        add(0, 6'h3F, 6'h00, 0, 2, E_DEC);
        add(0, 6'h3F, 6'h00, 0, 0, E_FETCH);
        // addi, no overflow
        add(0, 6'h08, 6'h00, 0, 1, E_FW);
        add(0, 6'h08, 6'h00, 0, 2, E_DEC);
        add(0, 6'h08, 6'h00, 0, 4, E_XI);
        add(0, 6'h08, 6'h00, 0, 6, E_WBI);
        add(0, 6'h08, 6'h00, 0, 0, E_FETCH);
        // addi and sub with overflow
        add(0, 6'h08, 6'h00, 1, 1, E_FW);
        add(0, 6'h08, 6'h00, 1, 2, E_DEC);
        add(0, 6'h08, 6'h00, 1, 4, E_XI);
`ifdef OVERFLOW_EXC_EN
        add(0, 6'h08, 6'h00, 1, 14, E_EXC);
`else
        add(0, 6'h08, 6'h00, 1, 6, E_WBI);
`endif
        add(0, 6'h08, 6'h00, 1, 0, E_FETCH);
        add(0, 6'h00, 6'h22, 1, 1, E_FW);
        add(0, 6'h00, 6'h22, 1, 2, E_DEC);
        add(0, 6'h00, 6'h22, 1, 3, E_XR_SUB);
`ifdef OVERFLOW_EXC_EN
        add(0, 6'h00, 6'h22, 1, 14, E_EXC);
`else
        add(0, 6'h00, 6'h22, 1, 5, E_WBR);
`endif
        add(0, 6'h00, 6'h22, 1, 0, E_FETCH);
        // reset in the middle of an R-type
        add(0, 6'h00, 6'h20, 0, 1, E_FW);
        add(0, 6'h00, 6'h20, 0, 2, E_DEC);
        add(1, 6'h00, 6'h20, 0, 0, E_FETCH);
        add(0, 6'h3F, 6'h00, 0, 1, E_FW);
        add(0, 6'h3F, 6'h00, 0, 2, E_DEC);
        add(0, 6'h3F, 6'h00, 0, 0, E_FETCH);

        foreach (vecs[i]) begin
            reset    = vecs[i].rst;
            opcode   = vecs[i].op;
            funct    = vecs[i].fn;
            overflow = vecs[i].ovf;
            step();
            check_val($sformatf("vec%0d_state", i), {28'd0, state}, {28'd0, vecs[i].st});
            check_val($sformatf("vec%0d_ctl", i), {13'd0, actual_ctl()}, {13'd0, vecs[i].ex});
        end

        // reset asserted while in MEM_RD_W: no write-back may follow
        opcode = 6'h23; funct = 6'h00; overflow = 1'b0; reset = 1'b0;
        for (int k = 0; k < 5; k++) step();
        check_val("lw_pre_reset_state", {28'd0, state}, 32'd9);
        reset = 1'b1;
        step();
        check_val("rst_in_s9_state", {28'd0, state}, 32'd0);
        check_val("rst_in_s9_reg_wr", {31'd0, reg_wr}, 32'd0);
        reset  = 1'b0;
        opcode = 6'h3F;
        for (int k = 0; k < 3; k++) begin
            step();
            check_val($sformatf("post_rst_reg_wr%0d", k), {31'd0, reg_wr}, 32'd0);
        end
        check_val("post_rst_state", {28'd0, state}, 32'd0);

        // per-opcode latency, FETCH back to FETCH, bounded
        funct = 6'h20;
        for (int j = 0; j < 7; j++) begin
            int cyc;
            opcode = lat_ops[j][5:0];
            cyc = 0;
            do begin
                step();
                cyc++;
            end while (state != 4'd0 && cyc < 20);
            check_val($sformatf("latency_op%0h", lat_ops[j]), cyc, lat_exp[j]);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // structural invariant on branch qualifiers, sampled away from the edge
    always @(negedge clk) begin
        if (!reset && state !== 4'bx) begin
            if (((isBEQ + isBNE + isBGT + isBLE) > 1) ||
                (pc_write && (isBEQ | isBNE | isBGT | isBLE))) begin
                n_checks++;
                n_errors++;
                $display("FAIL isb_exclusive: got isB=%b%b%b%b pc_write=%b, expected at most one and none with pc_write",
                         isBEQ, isBNE, isBGT, isBLE, pc_write);
            end
        end
    end

endmodule

`default_nettype wire
